// File: rtl/vga_timing_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_pattern_gen_if
// Groups the pixel-side signals of the VGA timing / pattern generator.
//   i_En          pixel enable, everything advances only when high
//   i_Mode        pattern select, sampled by the generator once per frame
//   i_Solid_RGB   solid colour {R,G,B} for pattern 1
//   o_H_Sync      horizontal sync (asserted level = SYNC_POL)
//   o_V_Sync      vertical sync (asserted level = SYNC_POL)
//   o_Active      visible-pixel flag
//   o_Col/o_Row   position of the pixel currently on the outputs
//   o_Frame_Start high while the outputs show pixel (0,0)
//   o_Red/Green/Blue colour channels
// master: the generator. slave: whoever drives enable/mode and consumes pixels.
// ----------------------------------------------------------------------------
interface vga_timing_pattern_gen_if #(
   parameter int COLOR_W = 3,
   parameter int COL_W   = 10,
   parameter int ROW_W   = 10
);
   logic                   i_En;
   logic [2:0]             i_Mode;
   logic [3*COLOR_W-1:0]   i_Solid_RGB;
   logic                   o_H_Sync;
   logic                   o_V_Sync;
   logic                   o_Active;
   logic [COL_W-1:0]       o_Col;
   logic [ROW_W-1:0]       o_Row;
   logic                   o_Frame_Start;
   logic [COLOR_W-1:0]     o_Red;
   logic [COLOR_W-1:0]     o_Green;
   logic [COLOR_W-1:0]     o_Blue;

   modport master (
      input  i_En, i_Mode, i_Solid_RGB,
      output o_H_Sync, o_V_Sync, o_Active, o_Col, o_Row, o_Frame_Start,
             o_Red, o_Green, o_Blue
   );

   modport slave (
      output i_En, i_Mode, i_Solid_RGB,
      input  o_H_Sync, o_V_Sync, o_Active, o_Col, o_Row, o_Frame_Start,
             o_Red, o_Green, o_Blue
   );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_pattern_gen
// VGA sync/porch timing plus test-pattern generation in one block. A col/row
// counter walks the full raster; one register stage turns the current count
// into sync, active, position, frame-start and RGB, so all outputs line up.
// Ports:
//   CLK  pixel clock
//   RST  asynchronous active-high reset
//   bus  vga_timing_pattern_gen_if.master (enable, mode, solid colour in;
//        syncs, active, col/row, frame start, RGB out)
// Patterns: 0 black, 1 solid, 2 eight colour bars, 3 checkerboard,
//           4 border, 5 grey gradient, 6/7 black.
// ----------------------------------------------------------------------------
module vga_timing_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int COLOR_W    = 3,
   parameter int SYNC_POL   = 0,
   parameter int CHECK_LOG2 = 5,
   parameter int GRAD_SHIFT = 7
) (
   input  logic                      CLK,
   input  logic                      RST,
   vga_timing_pattern_gen_if.master  bus
);
   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int   COL_W   = $clog2(H_TOTAL);
   localparam int   ROW_W   = $clog2(V_TOTAL);
   localparam int   BAR_W   = H_ACTIVE / 8;
   localparam int   SUB_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic SYNC_ON = (SYNC_POL != 0);

   typedef struct packed {
      logic                 hs;
      logic                 vs;
      logic                 act;
      logic                 fs;
      logic [COL_W-1:0]     col;
      logic [ROW_W-1:0]     row;
      logic [3*COLOR_W-1:0] rgb;
   } pix_t;

   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [SUB_W-1:0]   r_sub;   // position inside the current colour bar
   logic [2:0]         r_bar;   // colour bar index, tracks r_col without a divider
   logic [2:0]         r_mode;
   pix_t               r_out;
   pix_t               w_pix;

   logic               w_col_end, w_row_end, w_sub_end, w_active;
   logic               w_cbit, w_rbit, w_edge;
   logic [COLOR_W-1:0] w_grey;

   assign w_col_end = 32'(r_col) == H_TOTAL - 1;
   assign w_row_end = 32'(r_row) == V_TOTAL - 1;
   assign w_sub_end = 32'(r_sub) == BAR_W - 1;
   assign w_active  = (32'(r_col) < H_ACTIVE) && (32'(r_row) < V_ACTIVE);

   // Shift-and-mask keeps the pattern bit selects legal even when the
   // requested bit lies above the counter width (it simply reads as zero).
   assign w_cbit = ((r_col >> CHECK_LOG2) & COL_W'(1)) != '0;
   assign w_rbit = ((r_row >> CHECK_LOG2) & ROW_W'(1)) != '0;
   assign w_grey = COLOR_W'(r_col >> GRAD_SHIFT);
   assign w_edge = (r_col == '0) || (32'(r_col) == H_ACTIVE - 1) ||
                   (r_row == '0) || (32'(r_row) == V_ACTIVE - 1);

   // Raster counters; the mode is taken on the very last pixel of a frame so
   // it only ever changes between frames.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_col  <= '0;
         r_row  <= '0;
         r_sub  <= '0;
         r_bar  <= '0;
         r_mode <= '0;
      end else if (bus.i_En) begin
         if (w_col_end) begin
            r_col <= '0;
            r_sub <= '0;
            r_bar <= '0;
            if (w_row_end) begin
               r_row  <= '0;
               r_mode <= bus.i_Mode;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
            if (w_sub_end) begin
               r_sub <= '0;
               r_bar <= r_bar + 1'b1;
            end else begin
               r_sub <= r_sub + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_pix     = '0;
      w_pix.hs  = ((32'(r_col) >= H_ACTIVE + H_FP) &&
                   (32'(r_col) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ON : ~SYNC_ON;
      w_pix.vs  = ((32'(r_row) >= V_ACTIVE + V_FP) &&
                   (32'(r_row) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ON : ~SYNC_ON;
      w_pix.act = w_active;
      w_pix.fs  = (r_col == '0) && (r_row == '0);
      w_pix.col = r_col;
      w_pix.row = r_row;
      if (w_active) begin
         case (r_mode)
            3'd1:    w_pix.rgb = bus.i_Solid_RGB;
            3'd2:    w_pix.rgb = {{COLOR_W{r_bar[2]}}, {COLOR_W{r_bar[1]}},
                                  {COLOR_W{r_bar[0]}}};
            3'd3:    w_pix.rgb = {(3*COLOR_W){w_cbit ^ w_rbit}};
            3'd4:    w_pix.rgb = {(3*COLOR_W){w_edge}};
            3'd5:    w_pix.rgb = {w_grey, w_grey, w_grey};
            default: w_pix.rgb = '0;
         endcase
      end
   end

   // Single output stage shared by every output so they stay aligned.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_out    <= '0;
         r_out.hs <= ~SYNC_ON;
         r_out.vs <= ~SYNC_ON;
      end else if (bus.i_En) begin
         r_out <= w_pix;
      end
   end

   assign bus.o_H_Sync      = r_out.hs;
   assign bus.o_V_Sync      = r_out.vs;
   assign bus.o_Active      = r_out.act;
   assign bus.o_Frame_Start = r_out.fs;
   assign bus.o_Col         = r_out.col;
   assign bus.o_Row         = r_out.row;
   assign bus.o_Red         = r_out.rgb[3*COLOR_W-1 -: COLOR_W];
   assign bus.o_Green       = r_out.rgb[2*COLOR_W-1 -: COLOR_W];
   assign bus.o_Blue        = r_out.rgb[COLOR_W-1:0];
endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator that merges sync pulse generation, porch handling and pattern generation into one pipelined block. It has configurable resolution and porch/sync timing, sync polarity, colour depth, and a selectable pattern mode that is latched per frame. All outputs are registered and mutually aligned. It sits between the board clock and the VGA pins and replaces separate sync, porch and pattern instances at the top level.

Parameters:
H_ACTIVE, 640, visible pixels per line; must be divisible by 8
H_FP, 16, horizontal front porch in clocks
H_SYNC, 96, horizontal sync pulse width in clocks
H_BP, 48, horizontal back porch in clocks
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
COLOR_W, 3, bits per colour channel
SYNC_POL, 0, asserted sync level (0 = active-low)
CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels
GRAD_SHIFT, 7, column bit offset used for the gradient pattern

Ports:
CLK  in  1  pixel clock
RST  in  1  asynchronous, active-high reset
i_En  in  1  pixel enable; counters and outputs advance only when high
i_Mode  in  3  pattern select; sampled once per frame
i_Solid_RGB  in  3*COLOR_W  solid colour as {R,G,B}
o_H_Sync  out  1  horizontal sync at SYNC_POL level
o_V_Sync  out  1  vertical sync at SYNC_POL level
o_Active  out  1  high for visible pixels
o_Col  out  clog2(H_TOTAL)  column of the current output pixel
o_Row  out  clog2(V_TOTAL)  row of the current output pixel
o_Frame_Start  out  1  one-cycle pulse when the outputs show pixel (0,0)
o_Red  out  COLOR_W  red channel
o_Green  out  COLOR_W  green channel
o_Blue  out  COLOR_W  blue channel

Behaviour:
- The interface has one clock, CLK. RST is asynchronous and active-high.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset values of all outputs:
  - col, row, o_Col and o_Row = 0.
  - o_H_Sync and o_V_Sync = ~SYNC_POL (deasserted).
  - o_Active, o_Frame_Start and RGB = 0.
  - Mode register = 0 (black).
- Counters, on each cycle with i_En=1:
  - col increments.
  - At col = H_TOTAL-1, col wraps to 0 and row increments.
  - At row = V_TOTAL-1 with col = H_TOTAL-1, row wraps to 0.
- i_En=0: counters, mode register and all outputs hold their values. o_Frame_Start also holds.
- Latency: outputs for counter value (c,r) appear 1 clock after the enabled cycle in which the counter equals (c,r). All outputs (sync, active, col/row, RGB, frame_start) are registered in the same stage.
- Active region: col < H_ACTIVE and row < V_ACTIVE.
- Sync timing:
  - o_H_Sync = SYNC_POL when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
  - o_V_Sync = SYNC_POL when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC. It is row-based and spans whole lines.
- o_Frame_Start = 1 exactly when the registered outputs correspond to (0,0).
- Mode latch: the mode register loads i_Mode on the enabled cycle with col = H_TOTAL-1 and row = V_TOTAL-1. A change on i_Mode never alters a frame in progress. The first frame after reset uses mode 0.
- Patterns (active region only; RGB = 0 outside it):
  - 0: black.
  - 1: i_Solid_RGB.
  - 2: 8 vertical bars, each H_ACTIVE/8 wide. The bar index b increments without a divider (column sub-counter) and resets at col = 0. Red is all-ones if b[2], green if b[1], blue if b[0].
  - 3: checkerboard; white (all-ones) if col[CHECK_LOG2] ^ row[CHECK_LOG2], else black.
  - 4: border; white if col = 0, col = H_ACTIVE-1, row = 0 or row = V_ACTIVE-1, else black.
  - 5: grey gradient; all channels = col[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT].
  - 6, 7: reserved, black.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). After release, the first enabled cycle produces (0,0) outputs one clock later, with o_Frame_Start = 1.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12); COLOR_W=3; CHECK_LOG2=1.
1. Reset: assert RST mid-line with i_En=1 -> o_H_Sync=o_V_Sync=1, RGB=0 and o_Col=o_Row=0 with no clock edge. Release -> o_Frame_Start=1 one clock after the first enabled edge.
2. Line timing: free-run -> o_Active high for 16 clocks, o_H_Sync low for output cols 18-20 (3 clocks), line period 24 clocks.
3. Frame timing: o_V_Sync low for rows 9-10 (48 clocks). o_Frame_Start period = 288 clocks. o_Row wraps 11->0.
4. Colour bars: frame with mode 2 -> col 0-1 RGB=0/0/0; col 8-9 R=7,G=0,B=0; col 14-15 all 7; col 16 RGB=0.
5. Mode change mid-frame: set i_Mode from 1 to 3 at row 4 -> rest of frame stays solid. Next frame checkerboard: (0,0) black, (2,0) white, (2,2) black.
6. Enable stall: hold i_En=0 for 5 clocks at col 17 -> all outputs frozen. On resume the sync assertion at col 18 arrives exactly 5 clocks late.
